// File: rtl/sched_dp_engine.sv
// Microcoded datapath: ALU, MUL/DIV and LOGIC units sharing a register file,
// sequenced from a loadable schedule memory with a start/valid-ready handshake.
module sched_dp_engine #(
    parameter int WIDTH     = 32,
    parameter int NUM_IN    = 8,
    parameter int NUM_REGS  = 8,
    parameter int NUM_STEPS = 16,
    parameter int SELW      = $clog2(NUM_IN + NUM_REGS),
    parameter int RW        = $clog2(NUM_REGS),
    parameter int PW        = $clog2(NUM_STEPS),
    parameter int UFW       = 2 * SELW + 2 + 1 + RW,
    parameter int UW        = 3 * UFW + RW + 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    cfg_we,
    input  logic [PW-1:0]           cfg_addr,
    input  logic [UW-1:0]           cfg_data,
    input  logic [NUM_IN*WIDTH-1:0] in_data,
    input  logic                    start,
    output logic                    busy,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [WIDTH-1:0]        result,
    output logic                    div0,
    output logic                    done
);

    localparam int NSRC = 1 << SELW;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        OUT
    } state_e;

    typedef struct packed {
        logic [SELW-1:0] s1;
        logic [SELW-1:0] s2;
        logic [1:0]      op;
        logic            we;
        logic [RW-1:0]   dst;
    } ufield_t;

    typedef struct packed {
        logic          last;
        logic [RW-1:0] rsel;
        ufield_t       lg;
        ufield_t       mu;
        ufield_t       al;
    } uword_t;

    logic [UW-1:0]    sched_mem [NUM_STEPS];

    state_e           state_q, state_d;
    logic [PW-1:0]    pc_q, pc_d;
    logic [RW-1:0]    rsel_q, rsel_d;
    logic             div0_q, div0_d;
    logic             done_q, done_d;
    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] inbuf_q [NUM_IN];
    logic [WIDTH-1:0] inbuf_d [NUM_IN];
    logic [WIDTH-1:0] regs_q [NUM_REGS];
    logic [WIDTH-1:0] regs_d [NUM_REGS];

    uword_t           uw;
    logic [WIDTH-1:0] src [NSRC];
    logic [WIDTH-1:0] alu_a, alu_b, alu_y;
    logic [WIDTH-1:0] mul_a, mul_b, mul_y;
    logic [WIDTH-1:0] log_a, log_b, log_y;
    logic [2*WIDTH-1:0] prod;
    logic             mul_b_zero;
    logic             mul_div0;

    // Schedule is retained across reset so a loaded program survives aborts.
    always_ff @(posedge clk) begin
        if (cfg_we && state_q == IDLE) begin
            sched_mem[cfg_addr] <= cfg_data;
        end
    end

    assign uw = uword_t'(sched_mem[pc_q]);

    always_comb begin
        for (int k = 0; k < NSRC; k++) begin
            src[k] = '0;
        end
        for (int i = 0; i < NUM_IN; i++) begin
            src[i] = inbuf_q[i];
        end
        for (int r = 0; r < NUM_REGS; r++) begin
            src[NUM_IN+r] = regs_q[r];
        end
    end

    assign alu_a = src[uw.al.s1];
    assign alu_b = src[uw.al.s2];
    assign mul_a = src[uw.mu.s1];
    assign mul_b = src[uw.mu.s2];
    assign log_a = src[uw.lg.s1];
    assign log_b = src[uw.lg.s2];

    always_comb begin
        alu_y = '0;
        case (uw.al.op)
            2'b00:   alu_y = alu_a + alu_b;
            2'b01:   alu_y = alu_a - alu_b;
            2'b10:   alu_y = alu_a;
            default: alu_y = {{(WIDTH-1){1'b0}}, alu_a < alu_b};
        endcase
    end

    assign prod       = {{WIDTH{1'b0}}, mul_a} * {{WIDTH{1'b0}}, mul_b};
    assign mul_b_zero = (mul_b == '0);
    assign mul_div0   = uw.mu.we && mul_b_zero &&
                        (uw.mu.op == 2'b01 || uw.mu.op == 2'b10);

    always_comb begin
        mul_y = '0;
        case (uw.mu.op)
            2'b00:   mul_y = prod[WIDTH-1:0];
            2'b01:   mul_y = mul_b_zero ? '1 : mul_a / mul_b;
            2'b10:   mul_y = mul_b_zero ? mul_a : mul_a % mul_b;
            default: mul_y = prod[2*WIDTH-1:WIDTH];
        endcase
    end

    always_comb begin
        log_y = '0;
        case (uw.lg.op)
            2'b00:   log_y = log_a & log_b;
            2'b01:   log_y = log_a | log_b;
            2'b10:   log_y = log_a ^ log_b;
            default: log_y = ~log_a;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        rsel_d      = rsel_q;
        div0_d      = div0_q;
        done_d      = 1'b0;
        out_valid_d = out_valid_q;
        inbuf_d     = inbuf_q;
        regs_d      = regs_q;
        case (state_q)
            IDLE: begin
                if (start && !cfg_we) begin
                    state_d = RUN;
                    pc_d    = '0;
                    div0_d  = 1'b0;
                    for (int r = 0; r < NUM_REGS; r++) begin
                        regs_d[r] = '0;
                    end
                    for (int i = 0; i < NUM_IN; i++) begin
                        inbuf_d[i] = in_data[i*WIDTH +: WIDTH];
                    end
                end
            end
            RUN: begin
                // Later writes win: LOG over MUL over ALU.
                if (uw.al.we) regs_d[uw.al.dst] = alu_y;
                if (uw.mu.we) regs_d[uw.mu.dst] = mul_y;
                if (uw.lg.we) regs_d[uw.lg.dst] = log_y;
                if (mul_div0) div0_d = 1'b1;
                if (uw.last || pc_q == PW'(NUM_STEPS - 1)) begin
                    state_d     = OUT;
                    rsel_d      = uw.rsel;
                    out_valid_d = 1'b1;
                end else begin
                    pc_d = pc_q + 1'b1;
                end
            end
            OUT: begin
                if (out_ready) begin
                    state_d     = IDLE;
                    out_valid_d = 1'b0;
                    done_d      = 1'b1;
                end
            end
            default: begin
                state_d     = IDLE;
                out_valid_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            pc_q        <= '0;
            rsel_q      <= '0;
            div0_q      <= 1'b0;
            done_q      <= 1'b0;
            out_valid_q <= 1'b0;
            for (int i = 0; i < NUM_IN; i++) begin
                inbuf_q[i] <= '0;
            end
            for (int r = 0; r < NUM_REGS; r++) begin
                regs_q[r] <= '0;
            end
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            rsel_q      <= rsel_d;
            div0_q      <= div0_d;
            done_q      <= done_d;
            out_valid_q <= out_valid_d;
            inbuf_q     <= inbuf_d;
            regs_q      <= regs_d;
        end
    end

    assign busy      = (state_q != IDLE);
    assign out_valid = out_valid_q;
    assign result    = out_valid_q ? regs_q[rsel_q] : '0;
    assign div0      = div0_q;
    assign done      = done_q;

endmodule
